// File: rtl/pc_seq_pkg.sv
// Shared encodings and the fetch-address legality check for the program-counter unit.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_HALT  = 2'b10,
        ST_FAULT = 2'b11
    } pc_state_e;

    localparam logic [1:0] RT_BRANCH = 2'b00;
    localparam logic [1:0] RT_JUMP   = 2'b01;
    localparam logic [1:0] RT_JR     = 2'b10;
    localparam logic [1:0] RT_RSVD   = 2'b11;

    // Word aligned and no further than the last instruction slot; callers zero-extend to 64 bits.
    function automatic logic addr_ok(input logic [63:0] addr, input logic [63:0] last);
        return (addr[1:0] == 2'b00) && (addr <= last);
    endfunction

endpackage

// File: rtl/pc_loop_detector.sv
// Counts consecutive redirects that target the current PC and flags the one that reaches LOOP_LIMIT.
module pc_loop_detector #(
    parameter int XLEN       = 32,
    parameter int LOOP_LIMIT = 4
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            redir_take,
    input  logic            seq_take,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] target,
    output logic            limit_hit
);
    localparam int CW = $clog2(LOOP_LIMIT + 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d   = count_q;
        limit_hit = 1'b0;
        if (redir_take) begin
            if (target == pc) begin
                if (count_q >= CW'(LOOP_LIMIT - 1)) begin
                    count_d   = CW'(LOOP_LIMIT);
                    limit_hit = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end else begin
                count_d = '0;
            end
        end else if (seq_take) begin
            count_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) count_q <= '0;
        else       count_q <= count_d;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: boot vector select, redirect arbitration, self-loop halt and address traps.
// Optional run counters are built when PC_PERF_EN is defined.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                     XLEN       = 32,
    parameter int                     NPROG      = 4,
    parameter logic [NPROG*XLEN-1:0]  BOOT_VECS  = {32'd0, 32'd0, 32'd112, 32'd0},
    parameter int                     IMEM_BYTES = 512,
    parameter int                     LOOP_LIMIT = 4
) (
    input  logic                                    CLK,
    input  logic                                    Reset,
    input  logic [(NPROG > 1 ? $clog2(NPROG) : 1)-1:0] prog_sel,
    input  logic                                    run_en,
    input  logic                                    stall,
    input  logic                                    redir_valid,
    input  logic [1:0]                              redir_type,
    input  logic [XLEN-1:0]                         redir_target,
    output logic [XLEN-1:0]                         PC,
    output logic [XLEN-1:0]                         PCPlus4,
    output logic                                    pc_valid,
    output logic [1:0]                              state,
    output logic [XLEN-1:0]                         fault_addr,
    output logic [31:0]                             perf_cycles,
    output logic [31:0]                             perf_redirects
);
    localparam int          PSW  = (NPROG > 1) ? $clog2(NPROG) : 1;
    localparam logic [63:0] LAST = 64'(IMEM_BYTES - 4);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, fault_q, fault_d, boot_pc;
    logic            pc_valid_q;
    logic            run_go, redir_ok, redir_take, seq_take, limit_hit;

    // Every redirect kind moves the PC the same way; the type is carried for the interface only.
    logic [1:0] unused_redir_type;
    assign unused_redir_type = redir_type;

    always_comb begin
        boot_pc = BOOT_VECS[0 +: XLEN];
        for (int i = 1; i < NPROG; i++)
            if (prog_sel == PSW'(i)) boot_pc = BOOT_VECS[i*XLEN +: XLEN];
    end

    assign PCPlus4    = pc_q + XLEN'(4);
    assign run_go     = (state_q == ST_RUN) && run_en && !stall;
    assign redir_ok   = addr_ok(64'(redir_target), LAST);
    assign redir_take = run_go && redir_valid && redir_ok;
    assign seq_take   = run_go && !redir_valid;

    pc_loop_detector #(.XLEN(XLEN), .LOOP_LIMIT(LOOP_LIMIT)) u_loop (
        .CLK        (CLK),
        .Reset      (Reset),
        .redir_take (redir_take),
        .seq_take   (seq_take),
        .pc         (pc_q),
        .target     (redir_target),
        .limit_hit  (limit_hit)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        case (state_q)
            ST_IDLE: if (run_en) state_d = ST_RUN;
            ST_RUN: begin
                if (!run_en) begin
                    state_d = ST_IDLE;
                end else if (stall) begin
                    state_d = ST_RUN;
                end else if (redir_valid) begin
                    if (!redir_ok) begin
                        state_d = ST_FAULT;
                        fault_d = redir_target;
                    end else if (limit_hit) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = redir_target;
                    end
                end else if (!addr_ok(64'(PCPlus4), LAST)) begin
                    state_d = ST_FAULT;
                    fault_d = PCPlus4;
                end else begin
                    pc_d = PCPlus4;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= boot_pc;
            fault_q    <= '0;
            pc_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            pc_valid_q <= (state_d == ST_RUN);
        end
    end

    assign PC         = pc_q;
    assign pc_valid   = pc_valid_q;
    assign state      = state_q;
    assign fault_addr = fault_q;

`ifdef PC_PERF_EN
    logic [31:0] cycles_q, redirs_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            cycles_q <= '0;
            redirs_q <= '0;
        end else begin
            if (state_q == ST_RUN) cycles_q <= cycles_q + 32'd1;
            if (redir_take)        redirs_q <= redirs_q + 32'd1;
        end
    end

    assign perf_cycles    = cycles_q;
    assign perf_redirects = redirs_q;
`else
    assign perf_cycles    = 32'd0;
    assign perf_redirects = 32'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: table of per-edge vectors plus hand sequences for traps and reset.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        Reset, run_en, stall, redir_valid;
    logic [1:0]  prog_sel, prog_sel3, redir_type;
    logic [31:0] redir_target;
    logic [31:0] PC, PCPlus4, fault_addr, perf_cycles, perf_redirects;
    logic        pc_valid;
    logic [1:0]  state;
    logic [31:0] PC3, PCPlus4_3, fault_addr3, perf_cycles3, perf_redirects3;
    logic        pc_valid3;
    logic [1:0]  state3;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    pc_sequencer dut (
        .CLK(CLK), .Reset(Reset), .prog_sel(prog_sel), .run_en(run_en), .stall(stall),
        .redir_valid(redir_valid), .redir_type(redir_type), .redir_target(redir_target),
        .PC(PC), .PCPlus4(PCPlus4), .pc_valid(pc_valid), .state(state), .fault_addr(fault_addr),
        .perf_cycles(perf_cycles), .perf_redirects(perf_redirects)
    );

    pc_sequencer #(.NPROG(3), .BOOT_VECS({32'd200, 32'd112, 32'd36})) dut3 (
        .CLK(CLK), .Reset(Reset), .prog_sel(prog_sel3), .run_en(run_en), .stall(stall),
        .redir_valid(redir_valid), .redir_type(redir_type), .redir_target(redir_target),
        .PC(PC3), .PCPlus4(PCPlus4_3), .pc_valid(pc_valid3), .state(state3), .fault_addr(fault_addr3),
        .perf_cycles(perf_cycles3), .perf_redirects(perf_redirects3)
    );

    typedef struct {
        logic        run_en;
        logic        stall;
        logic        rv;
        logic [1:0]  rt;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic [1:0]  e_st;
        logic        e_valid;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic s, input logic v, input logic [1:0] t,
                                input logic [31:0] tg, input logic [31:0] epc,
                                input logic [1:0] est, input logic eval);
        vec_t x;
        x.run_en = r; x.stall = s; x.rv = v; x.rt = t; x.tgt = tg;
        x.e_pc = epc; x.e_st = est; x.e_valid = eval;
        vecs.push_back(x);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        Reset = 1'b1; prog_sel = 2'd1; prog_sel3 = 2'd3; run_en = 1'b0; stall = 1'b0;
        redir_valid = 1'b0; redir_type = 2'b00; redir_target = 32'd0;

        // Boot vector selection, including out-of-range index on the 3-program build
        step();
        chk("t1_pc_prog1", PC, 32'd112);
        chk("t1_state", {30'd0, state}, 32'd0);
        chk("t1_valid", {31'd0, pc_valid}, 32'd0);
        chk("t1_fault", fault_addr, 32'd0);
        chk("t1_pcplus4", PCPlus4, 32'd116);
        chk("t1_nprog3_oor", PC3, 32'd36);
        prog_sel = 2'd3;
        step();
        chk("t1_pc_prog3", PC, 32'd0);

        Reset = 1'b0;
        //  run stall rv  type   target   pc      state  valid
        add(1, 0, 0, 2'b00, 32'd0,  32'd0,  2'd1, 1);
        add(1, 0, 0, 2'b00, 32'd0,  32'd4,  2'd1, 1);
        add(1, 0, 0, 2'b00, 32'd0,  32'd8,  2'd1, 1);
        add(1, 0, 0, 2'b00, 32'd0,  32'd12, 2'd1, 1);
        add(1, 1, 0, 2'b00, 32'd0,  32'd12, 2'd1, 1);
        add(1, 1, 0, 2'b00, 32'd0,  32'd12, 2'd1, 1);
        add(1, 0, 0, 2'b00, 32'd0,  32'd16, 2'd1, 1);
        add(0, 0, 0, 2'b00, 32'd0,  32'd16, 2'd0, 0);
        add(1, 0, 0, 2'b00, 32'd0,  32'd16, 2'd1, 1);
        add(1, 1, 1, 2'b01, 32'd40, 32'd16, 2'd1, 1);
        add(1, 0, 1, 2'b01, 32'd40, 32'd40, 2'd1, 1);
        add(1, 0, 1, 2'b01, 32'd40, 32'd40, 2'd1, 1);
        add(1, 0, 1, 2'b01, 32'd40, 32'd40, 2'd1, 1);
        add(1, 0, 1, 2'b00, 32'd44, 32'd44, 2'd1, 1);
        add(1, 0, 1, 2'b10, 32'd40, 32'd40, 2'd1, 1);
        add(1, 0, 1, 2'b01, 32'd40, 32'd40, 2'd1, 1);
        add(1, 0, 1, 2'b01, 32'd40, 32'd40, 2'd1, 1);
        add(1, 1, 1, 2'b01, 32'd40, 32'd40, 2'd1, 1);
        add(1, 0, 1, 2'b01, 32'd40, 32'd40, 2'd1, 1);
        add(1, 0, 1, 2'b11, 32'd40, 32'd40, 2'd2, 0);
        add(1, 0, 0, 2'b00, 32'd0,  32'd40, 2'd2, 0);

        foreach (vecs[i]) begin
            run_en = vecs[i].run_en; stall = vecs[i].stall; redir_valid = vecs[i].rv;
            redir_type = vecs[i].rt; redir_target = vecs[i].tgt;
            step();
            chk($sformatf("vec%0d_pc", i), PC, vecs[i].e_pc);
            chk($sformatf("vec%0d_state", i), {30'd0, state}, {30'd0, vecs[i].e_st});
            chk($sformatf("vec%0d_valid", i), {31'd0, pc_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("vec%0d_fault", i), fault_addr, 32'd0);
`ifdef PC_PERF_EN
            if (i == 10) chk("vec10_perf_redirects", perf_redirects, 32'd1);
`else
            chk($sformatf("vec%0d_perf_cycles", i), perf_cycles, 32'd0);
            chk($sformatf("vec%0d_perf_redirects", i), perf_redirects, 32'd0);
`endif
        end

        // Misaligned redirect traps and is sticky
        Reset = 1'b1; prog_sel = 2'd1; run_en = 1'b0; stall = 1'b0; redir_valid = 1'b0;
        step();
        Reset = 1'b0; run_en = 1'b1;
        step();
        chk("t5_run_pc", PC, 32'd112);
        redir_valid = 1'b1; redir_type = 2'b01; redir_target = 32'd42;
        step();
        chk("t5_mis_state", {30'd0, state}, 32'd3);
        chk("t5_mis_fault", fault_addr, 32'd42);
        chk("t5_mis_pc", PC, 32'd112);
        chk("t5_mis_valid", {31'd0, pc_valid}, 32'd0);
        redir_valid = 1'b0;
        step();
        chk("t5_sticky_state", {30'd0, state}, 32'd3);
        chk("t5_sticky_pc", PC, 32'd112);

        // Reset aborts FAULT; then last legal slot, then sequential step past it
        Reset = 1'b1;
        step();
        chk("t5_rst_state", {30'd0, state}, 32'd0);
        chk("t5_rst_pc", PC, 32'd112);
        chk("t5_rst_fault", fault_addr, 32'd0);
        Reset = 1'b0;
        step();
        redir_valid = 1'b1; redir_target = 32'd508;
        step();
        chk("t6_pc_508", PC, 32'd508);
        chk("t6_state_run", {30'd0, state}, 32'd1);
        redir_valid = 1'b0;
        step();
        chk("t6_seq_state", {30'd0, state}, 32'd3);
        chk("t6_seq_fault", fault_addr, 32'd512);

        // Redirect one slot beyond the end of memory
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        step();
        redir_valid = 1'b1; redir_target = 32'd512;
        step();
        chk("t5_oor_state", {30'd0, state}, 32'd3);
        chk("t5_oor_fault", fault_addr, 32'd512);
        chk("t5_oor_pc", PC, 32'd112);
`ifndef PC_PERF_EN
        chk("t6_perf_cycles_end", perf_cycles, 32'd0);
        chk("t6_perf_redirects_end", perf_redirects, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
